sorted_serializer: RTL

- Downstream consumer of the bitonic sorter's wrapper output (`sorted` vector plus `valid_out` pulse).
- Buffers complete sorted vectors and streams them out one element per beat over a ready/valid interface, index 0 first (ascending order).
- The sorter has no backpressure, so this block absorbs bursts in a small vector buffer and counts vectors it must drop.

---
 rtl/bitonic_pkg.sv | 12 +
 rtl/vec_fifo.sv | 56 +++++
 rtl/sorted_serializer.sv | 87 ++++++++
 3 files changed

// File: rtl/bitonic_pkg.sv
// Shared constants and helpers for the bitonic sorter family of blocks.
package bitonic_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH = 8;

   // Keeps pointer widths at least one bit wide when a dimension is 1.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vec_fifo.sv
// FIFO of whole sorted vectors; push and pop may coincide, including when full.
module vec_fifo
   import bitonic_pkg::*;
#(
   parameter int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned DEPTH   = DEFAULT_DEPTH,
   parameter int unsigned NUM_BUF = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [0:DEPTH-1][WIDTH-1:0]   din,
   output logic                          full,
   output logic                          empty,
   output logic [0:DEPTH-1][WIDTH-1:0]   head
);

   localparam int unsigned PtrW = clog2_min1(NUM_BUF);
   localparam int unsigned CntW = $clog2(NUM_BUF + 1);

   logic [0:DEPTH-1][WIDTH-1:0] mem [NUM_BUF];
   logic [PtrW-1:0]             rd_ptr;
   logic [PtrW-1:0]             wr_ptr;
   logic [CntW-1:0]             count;

   // Pointers wrap explicitly because NUM_BUF need not be a power of two.
   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(NUM_BUF - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign full  = (count == CntW'(NUM_BUF));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/sorted_serializer.sv
// Buffers sorted vectors from the sorter and streams them out one element per
// beat, counting vectors that arrive when no buffer entry can take them.
module sorted_serializer
   import bitonic_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned NUM_BUF   = 2,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_in,
   input  logic [0:DEPTH-1][WIDTH-1:0]  vec_in,
   input  logic                         out_ready,
   input  logic                         clr_stats,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH)-1:0]     out_idx,
   output logic                         out_last,
   output logic                         busy,
   output logic                         overflow,
   output logic [CNT_WIDTH-1:0]         drop_count
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   logic                        full;
   logic                        empty;
   logic [0:DEPTH-1][WIDTH-1:0] head;
   logic                        last_beat;
   logic                        xfer;
   logic                        pop;
   logic                        accept;
   logic                        drop;

   assign busy      = !empty;
   assign out_valid = busy;
   assign last_beat = (out_idx == IdxW'(DEPTH - 1));
   assign out_last  = out_valid && last_beat;
   assign out_data  = out_valid ? head[out_idx] : '0;

   assign xfer   = out_valid && out_ready;
   assign pop    = xfer && last_beat;
   // A full buffer still accepts when its head vector leaves this cycle.
   assign accept = valid_in && (!full || pop);
   assign drop   = valid_in && !accept;

   vec_fifo #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .NUM_BUF (NUM_BUF)
   ) u_vec_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   (vec_in),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_idx <= '0;
      end else if (xfer) begin
         out_idx <= last_beat ? '0 : out_idx + 1'b1;
      end
   end

   // A drop in the same cycle as clr_stats counts as the first new drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_stats)             drop_count <= CNT_WIDTH'(1);
         else if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end else if (clr_stats) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule
